// File: rtl/mult_unit_if.sv
// Handshake and data bundle between the pipeline control and the HI/LO multiplier.
// The master drives requests and mthi/mtlo data; the slave returns status and HI/LO.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier with HI/LO registers for mult/multu/mfhi/mflo/mthi/mtlo.
// Signed products multiply magnitudes, then negate the result in a single fixup cycle.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  mult_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      count_reg;
  logic               neg_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_fixed;

  // The most negative operand maps onto itself, which is its correct unsigned magnitude.
  assign a_mag     = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign partial   = {{WIDTH{1'b0}}, mcand_reg} << count_reg;
  assign acc_fixed = neg_reg ? -acc_reg : acc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            // A start in the same cycle as mthi/mtlo takes precedence; the writes are dropped.
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            neg_reg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else begin
            if (bus.wr_hi) hi_reg <= bus.wdata;
            if (bus.wr_lo) lo_reg <= bus.wdata;
          end
        end
        RUN: begin
          if (mplier_reg[count_reg]) acc_reg <= acc_reg + partial;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) state_reg <= FIX;
        end
        FIX: begin
          {hi_reg, lo_reg} <= acc_fixed;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32×32 multiplier with HI/LO result registers for the MIPS core, serving mult, multu, mfhi, mflo, mthi and mtlo. It sits beside the ALU inside the datapath. The control unit issues a one-cycle start, stalls the pipeline while busy is high, then reads hi/lo for mfhi/mflo. It computes by 32 shift-add iterations plus one sign-fixup cycle, which keeps area small at the cost of latency.

## Interface
- WIDTH, 32, operand width; hi/lo are WIDTH each and the product is 2*WIDTH.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  one-cycle request to multiply a by b; honoured only in IDLE.
- is_signed  in  1  1 = mult (two's complement), 0 = multu; sampled with start.
- a  in  WIDTH  multiplicand (rs); sampled with start.
- b  in  WIDTH  multiplier (rt); sampled with start.
- wr_hi  in  1  mthi: load hi from wdata; honoured only in IDLE.
- wr_lo  in  1  mtlo: load lo from wdata; honoured only in IDLE.
- wdata  in  WIDTH  data for mthi/mtlo.
- busy  out  1  high from the edge after start is accepted until the result is written.
- done  out  1  one-cycle pulse in the cycle after hi/lo take the new result.
- hi  out  WIDTH  upper product half / HI register; driven directly from the register.
- lo  out  WIDTH  lower product half / LO register; driven directly from the register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1 (edge E0):
  - latch mcand = |a|, mplier = |b| when is_signed, otherwise raw values;
  - latch neg = is_signed & (a[31] ^ b[31]);
  - acc (2*WIDTH) = 0, count = 0, go to RUN.
- RUN, one iteration per edge:
  - if mplier[count] = 1, acc += mcand << count;
  - count++;
  - after iteration WIDTH-1 (count wraps to WIDTH), go to FIX.
- FIX, one edge:
  - {hi,lo} = neg ? -acc : acc (2*WIDTH two's complement, truncated);
  - go to IDLE.
- Magnitude of 0x80000000 is 0x80000000 as an unsigned WIDTH-bit value; no overflow is possible in a 2*WIDTH accumulator.
- IDLE with wr_hi/wr_lo: the write takes effect on that edge; both may assert together.
- start together with wr_hi/wr_lo in IDLE: start wins and the writes are dropped.
- start, wr_hi and wr_lo are ignored in RUN and FIX, and hi/lo hold their old values until FIX.
- Operands are sampled only at E0; later changes to a, b or is_signed have no effect.

## Timing
- Reset values:
  - state = IDLE;
  - busy = 0, done = 0, hi = 0, lo = 0;
  - acc, count and neg are cleared.
- Reset has priority over every input in every state. Reset asserted mid-RUN or mid-FIX aborts the operation: no done pulse, and hi/lo read 0.
- Latency with start accepted at edge E0:
  - busy = 1 after E0;
  - RUN iterations on E1..E32;
  - FIX on E33: hi/lo get the new value, busy = 0, done = 1;
  - done = 0 after E34.
- Total is WIDTH+1 edges from acceptance to result.
- A new start is accepted at E33+1 at the earliest (state is IDLE after E33), giving back-to-back throughput of one multiply per 34 cycles.
- busy is a registered output, so the control stall can use it combinationally in the cycle after start. Control must also stall in the start cycle itself, without relying on busy.
- hi/lo outputs change only on an mthi/mtlo edge, a FIX edge or reset.

## Test plan
- Unsigned 7×6:
  - start with is_signed=0, a=7, b=6 → hi=0x00000000, lo=0x0000002A;
  - busy is high for exactly 33 cycles, and done pulses once, 33 edges after start.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed cases:
  - −3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1;
  - 0x80000000×0x80000000 → hi=0x40000000, lo=0x00000000;
  - −1×0 → hi=0, lo=0.
- mthi/mtlo:
  - in IDLE, wr_hi with wdata=0x12345678, then wr_lo with wdata=0x9ABCDEF0 → hi/lo read those values;
  - during RUN, wr_hi with wdata=0xDEADBEEF → ignored, and the final result is unaffected.
- Ignored start: a second start with different operands at cycle 10 of RUN is ignored, and the result of the first multiply is produced at the original time.
- Reset mid-operation: reset asserted at cycle 15 of RUN (after mthi set hi=0x1) → after that edge busy=0, done=0, hi=0, lo=0, and no done pulse follows; a fresh 2×3 multiply then gives lo=6.
